dice_roll_sequencer: RTL

//  Controller that turns one roll-button press into a sequence of die draws from the

---
 rtl/dice_roll_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/dice_roll_sequencer.sv
// Roll-button controller: draws dice over a req/ack handshake, combines them per roll mode and
// presents one total. Optional button debouncer enabled by defining DICE_SEQ_DEBOUNCE_EN.
module dice_roll_sequencer #(
    parameter int unsigned MAX_DICE        = 8,
    parameter int unsigned ACK_TIMEOUT     = 255,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       roll_btn,
    input  logic [2:0] num_dice,
    input  logic [1:0] roll_mode,
    input  logic [4:0] modifier,
    output logic       die_req,
    input  logic       die_ack,
    input  logic [4:0] die_value,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic       crit_hi,
    output logic       crit_lo,
    output logic       timeout_err
);

    localparam int unsigned CntW = $clog2(MAX_DICE + 1);
    localparam int unsigned TimW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StGap, StFin} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [TimW-1:0] timer_q, timer_d;
    logic [7:0]      acc_q, acc_d;
    logic [1:0]      mode_q, mode_d;
    logic [4:0]      mod_q, mod_d;
    logic            single_q, single_d;
    logic [7:0]      result_q, result_d;
    logic            result_valid_q, result_valid_d;
    logic            crit_hi_q, crit_hi_d;
    logic            crit_lo_q, crit_lo_d;
    logic            timeout_q, timeout_d;

    logic sync1_q, sync2_q, lvl_prev_q;
    logic btn_lvl;
    logic start;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            sync1_q    <= roll_btn;
            sync2_q    <= sync1_q;
            lvl_prev_q <= btn_lvl;
        end
    end

`ifdef DICE_SEQ_DEBOUNCE_EN
    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DbW-1:0] db_cnt_q;
    logic           db_lvl_q;

    // Level follows the synchronised button only after DEBOUNCE_CYCLES differing cycles in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
        end else if (sync2_q == db_lvl_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_q <= '0;
            db_lvl_q <= sync2_q;
        end else begin
            db_cnt_q <= db_cnt_q + DbW'(1);
        end
    end
    assign btn_lvl = db_lvl_q;
`else
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
    assign btn_lvl = sync2_q;
`endif

    assign start = btn_lvl & ~lvl_prev_q;

    logic [7:0] die_ext;
    logic [7:0] fold;
    logic       pair_mode;

    assign die_ext   = {3'b000, die_value};
    assign pair_mode = (roll_mode == 2'b01) || (roll_mode == 2'b10);

    always_comb begin
        unique case (mode_q)
            2'b01:   fold = (die_ext > acc_q) ? die_ext : acc_q;
            2'b10:   fold = (die_ext < acc_q) ? die_ext : acc_q;
            default: fold = acc_q + die_ext;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        timer_d        = timer_q;
        acc_d          = acc_q;
        mode_d         = mode_q;
        mod_d          = mod_q;
        single_d       = single_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        crit_hi_d      = 1'b0;
        crit_lo_d      = 1'b0;
        timeout_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = roll_mode;
                    mod_d   = modifier;
                    timer_d = '0;
                    acc_d   = (roll_mode == 2'b10) ? 8'd31 : 8'd0;
                    if (pair_mode) begin
                        count_d  = CntW'(2);
                        single_d = 1'b1;
                    end else begin
                        if (num_dice == 3'd0) begin
                            count_d = CntW'(1);
                        end else if (CntW'(num_dice) > CntW'(MAX_DICE)) begin
                            count_d = CntW'(MAX_DICE);
                        end else begin
                            count_d = CntW'(num_dice);
                        end
                        single_d = (num_dice <= 3'd1);
                    end
                    state_d = StReq;
                end
            end
            StReq: begin
                if (die_ack) begin
                    acc_d   = fold;
                    count_d = count_q - CntW'(1);
                    timer_d = '0;
                    state_d = (count_q == CntW'(1)) ? StFin : StGap;
                end else if (timer_q == TimW'(ACK_TIMEOUT - 1)) begin
                    timer_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    timer_d = timer_q + TimW'(1);
                end
            end
            StGap: begin
                timer_d = '0;
                state_d = StReq;
            end
            StFin: begin
                result_d       = acc_q + {3'b000, mod_q};
                result_valid_d = 1'b1;
                crit_hi_d      = single_q && (acc_q == 8'd20);
                crit_lo_d      = single_q && (acc_q == 8'd1);
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            count_q        <= '0;
            timer_q        <= '0;
            acc_q          <= '0;
            mode_q         <= '0;
            mod_q          <= '0;
            single_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            crit_hi_q      <= 1'b0;
            crit_lo_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            timer_q        <= timer_d;
            acc_q          <= acc_d;
            mode_q         <= mode_d;
            mod_q          <= mod_d;
            single_q       <= single_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            crit_hi_q      <= crit_hi_d;
            crit_lo_q      <= crit_lo_d;
            timeout_q      <= timeout_d;
        end
    end

    assign die_req      = (state_q == StReq);
    assign busy         = (state_q != StIdle);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign crit_hi      = crit_hi_q;
    assign crit_lo      = crit_lo_q;
    assign timeout_err  = timeout_q;

endmodule
